// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined WIDTH-bit add/subtract with carry-in.
// The adder is cut into STAGES carry segments of SEG = WIDTH/STAGES bits.
// Each stage adds one slice and registers the partial result, the carry
// out of the slice, and the B' bits that later stages still need.
// Optional feature macro: PIPE_ADDSUB_SAT_EN. When it is defined, the last
// stage clamps out_sum to the signed max/min on overflow. out_carry and out_ovf
// still report the raw adder result.
//
// Handshake: a beat moves on a rising edge when its valid is high and the
// receiver's ready is high. An upstream holds its beat stable until it moves.
// in_ready means "stage 0 can load this cycle". out_valid is the valid bit of
// the last stage. While out_valid && !out_ready the outputs stay unchanged.
module pipe_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_addsub: illegal WIDTH/STAGES combination");
    end

    // Per-stage state, gathered into arrays so neighbouring stages can reach it.
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_c_q;
    logic [WIDTH-1:0]  w_acc_q [STAGES];
    logic [STAGES-1:0] w_en;

    // A stage can load when it is empty or its beat leaves this cycle.
    // The chain is evaluated from the output backwards, so a bubble is always filled.
    always_comb begin
        w_en       = '0;
        w_en[LAST] = !w_v[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            w_en[k] = !w_v[k] || w_en[k+1];
        end
    end

    assign in_ready  = w_en[0];
    assign out_valid = w_v[LAST];
    assign out_sum   = w_acc_q[LAST];
    assign out_carry = w_c_q[LAST];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;       // lowest bit handled by this stage
        localparam int BW = WIDTH - LO;    // B' bits still pending at this stage

        // w_acc holds the finished sum bits below LO and the raw A bits from LO upward.
        logic [WIDTH-1:0] w_acc;
        logic [BW-1:0]    w_b;
        logic             w_cin;
        logic             w_vin;
        logic [SEG:0]     w_seg;
        logic [WIDTH-1:0] w_acc_nxt;
        logic [WIDTH-1:0] w_acc_d;
        logic             w_load;
        logic             r_v;
        logic             r_c;
        logic [WIDTH-1:0] r_acc;

        if (k == 0) begin : g_src
            assign w_acc = in_a;
            assign w_b   = in_sub ? ~in_b : in_b;
            assign w_cin = in_sub ^ in_cin;
            assign w_vin = in_valid;
        end else begin : g_src
            assign w_acc = w_acc_q[k-1];
            assign w_b   = g_stage[k-1].g_fwd.r_bhi;
            assign w_cin = w_c_q[k-1];
            assign w_vin = w_v[k-1];
        end

        assign w_seg  = {1'b0, w_acc[LO +: SEG]} + {1'b0, w_b[SEG-1:0]}
                      + {{SEG{1'b0}}, w_cin};
        assign w_load = w_en[k] && w_vin;

        // Put this stage's slice of the sum in place of the A bits it used.
        always_comb begin
            w_acc_nxt            = w_acc;
            w_acc_nxt[LO +: SEG] = w_seg[SEG-1:0];
        end

        if (k < LAST) begin : g_fwd
            logic [BW-SEG-1:0] r_bhi;

            // Forward the B' bits that later stages still need.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_bhi <= '0;
                end else if (w_load) begin
                    r_bhi <= w_b[BW-1:SEG];
                end
            end

            assign w_acc_d = w_acc_nxt;
        end else begin : g_out
            logic w_ovf;
            logic r_ovf;

            // Carry into the MSB is recovered from the MSB sum bit and the MSB operand bits.
            assign w_ovf = w_seg[SEG-1] ^ w_acc[WIDTH-1] ^ w_b[BW-1] ^ w_seg[SEG];

`ifdef PIPE_ADDSUB_SAT_EN
            // On overflow, clamp to the signed limit on the side that A's sign selects.
            always_comb begin
                w_acc_d = w_acc_nxt;
                if (w_ovf) begin
                    w_acc_d = w_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`else
            assign w_acc_d = w_acc_nxt;
`endif

            // Overflow flag for the output beat. It loads only with the data.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_ovf <= 1'b0;
                end else if (w_load) begin
                    r_ovf <= w_ovf;
                end
            end

            assign out_ovf = r_ovf;
        end

        // Valid bit: take the upstream valid whenever this stage can load.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_v <= 1'b0;
            end else if (w_en[k]) begin
                r_v <= w_vin;
            end
        end

        // Data and carry registers change only when a beat is loaded.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_acc <= '0;
                r_c   <= 1'b0;
            end else if (w_load) begin
                r_acc <= w_acc_d;
                r_c   <= w_seg[SEG];
            end
        end

        assign w_v[k]     = r_v;
        assign w_c_q[k]   = r_c;
        assign w_acc_q[k] = r_acc;
    end
endmodule
